// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: captures the gated decode control word and operands, turns
// stall/flush into bubbles, freezes on hold and counts inserted bubbles with saturation.
module id_ex_pipeline_reg #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      hold,
  input  logic                      id_valid,
  input  logic                      reg_dst_in,
  input  logic                      alu_src_in,
  input  logic                      mem_read_in,
  input  logic                      mem_write_in,
  input  logic                      reg_write_in,
  input  logic                      mem_to_reg_in,
  input  logic [2:0]                alu_op_in,
  input  logic [DATA_WIDTH-1:0]     pc_plus4_in,
  input  logic [DATA_WIDTH-1:0]     rd1_in,
  input  logic [DATA_WIDTH-1:0]     rd2_in,
  input  logic [DATA_WIDTH-1:0]     imm_in,
  input  logic [REG_ADDR_WIDTH-1:0] rs_in,
  input  logic [REG_ADDR_WIDTH-1:0] rt_in,
  input  logic [REG_ADDR_WIDTH-1:0] rd_in,
  output logic                      ex_reg_dst,
  output logic                      ex_alu_src,
  output logic                      ex_mem_read,
  output logic                      ex_mem_write,
  output logic                      ex_reg_write,
  output logic                      ex_mem_to_reg,
  output logic [2:0]                ex_alu_op,
  output logic [DATA_WIDTH-1:0]     ex_pc_plus4,
  output logic [DATA_WIDTH-1:0]     ex_rd1,
  output logic [DATA_WIDTH-1:0]     ex_rd2,
  output logic [DATA_WIDTH-1:0]     ex_imm,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs,
  output logic [REG_ADDR_WIDTH-1:0] ex_rt,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      ex_valid,
  output logic [CNT_WIDTH-1:0]      bubble_cnt
);

  logic                      r_reg_dst;
  logic                      r_alu_src;
  logic                      r_mem_read;
  logic                      r_mem_write;
  logic                      r_reg_write;
  logic                      r_mem_to_reg;
  logic [2:0]                r_alu_op;
  logic [DATA_WIDTH-1:0]     r_pc_plus4;
  logic [DATA_WIDTH-1:0]     r_rd1;
  logic [DATA_WIDTH-1:0]     r_rd2;
  logic [DATA_WIDTH-1:0]     r_imm;
  logic [REG_ADDR_WIDTH-1:0] r_rs;
  logic [REG_ADDR_WIDTH-1:0] r_rt;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic                      r_valid;
  logic [CNT_WIDTH-1:0]      r_bubble_cnt;
  logic                      r_flush_pending;

  logic w_bubble;
  logic w_load;
  logic w_ctrl_en;
  logic w_cnt_sat;

  // A flush seen during hold is remembered so the kill still lands once hold drops.
  assign w_bubble  = !hold && (flush || r_flush_pending || stall);
  assign w_load    = !hold && !w_bubble;
  assign w_ctrl_en = w_load && id_valid;
  assign w_cnt_sat = &r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_reg_dst       <= 1'b0;
      r_alu_src       <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_reg_write     <= 1'b0;
      r_mem_to_reg    <= 1'b0;
      r_alu_op        <= 3'b000;
      r_pc_plus4      <= '0;
      r_rd1           <= '0;
      r_rd2           <= '0;
      r_imm           <= '0;
      r_rs            <= '0;
      r_rt            <= '0;
      r_rd            <= '0;
      r_valid         <= 1'b0;
      r_bubble_cnt    <= '0;
      r_flush_pending <= 1'b0;
    end else if (hold) begin
      if (flush) begin
        r_flush_pending <= 1'b1;
      end
    end else begin
      // Control is zero for bubbles and for invalid ID slots alike.
      r_reg_dst       <= w_ctrl_en & reg_dst_in;
      r_alu_src       <= w_ctrl_en & alu_src_in;
      r_mem_read      <= w_ctrl_en & mem_read_in;
      r_mem_write     <= w_ctrl_en & mem_write_in;
      r_reg_write     <= w_ctrl_en & reg_write_in;
      r_mem_to_reg    <= w_ctrl_en & mem_to_reg_in;
      r_alu_op        <= w_ctrl_en ? alu_op_in : 3'b000;
      r_pc_plus4      <= w_load ? pc_plus4_in : '0;
      r_rd1           <= w_load ? rd1_in      : '0;
      r_rd2           <= w_load ? rd2_in      : '0;
      r_imm           <= w_load ? imm_in      : '0;
      r_rs            <= w_load ? rs_in       : '0;
      r_rt            <= w_load ? rt_in       : '0;
      r_rd            <= w_load ? rd_in       : '0;
      r_valid         <= w_load & id_valid;
      r_flush_pending <= 1'b0;
      if (w_bubble && !w_cnt_sat) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
    end
  end

  assign ex_reg_dst    = r_reg_dst;
  assign ex_alu_src    = r_alu_src;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_to_reg = r_mem_to_reg;
  assign ex_alu_op     = r_alu_op;
  assign ex_pc_plus4   = r_pc_plus4;
  assign ex_rd1        = r_rd1;
  assign ex_rd2        = r_rd2;
  assign ex_imm        = r_imm;
  assign ex_rs         = r_rs;
  assign ex_rt         = r_rt;
  assign ex_rd         = r_rd;
  assign ex_valid      = r_valid;
  assign bubble_cnt    = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Directed bench for id_ex_pipeline_reg; 4-bit bubble counter so saturation is reachable.
module tb_id_ex_pipeline_reg;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, hold, id_valid;
  logic        reg_dst_in, alu_src_in, mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in;
  logic [2:0]  alu_op_in;
  logic [31:0] pc_plus4_in, rd1_in, rd2_in, imm_in;
  logic [4:0]  rs_in, rt_in, rd_in;
  logic        ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic [2:0]  ex_alu_op;
  logic [31:0] ex_pc_plus4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_valid;
  logic [3:0]  bubble_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_pipeline_reg #(
    .DATA_WIDTH    (32),
    .REG_ADDR_WIDTH(5),
    .CNT_WIDTH     (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .hold         (hold),
    .id_valid     (id_valid),
    .reg_dst_in   (reg_dst_in),
    .alu_src_in   (alu_src_in),
    .mem_read_in  (mem_read_in),
    .mem_write_in (mem_write_in),
    .reg_write_in (reg_write_in),
    .mem_to_reg_in(mem_to_reg_in),
    .alu_op_in    (alu_op_in),
    .pc_plus4_in  (pc_plus4_in),
    .rd1_in       (rd1_in),
    .rd2_in       (rd2_in),
    .imm_in       (imm_in),
    .rs_in        (rs_in),
    .rt_in        (rt_in),
    .rd_in        (rd_in),
    .ex_reg_dst   (ex_reg_dst),
    .ex_alu_src   (ex_alu_src),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_reg_write (ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_op    (ex_alu_op),
    .ex_pc_plus4  (ex_pc_plus4),
    .ex_rd1       (ex_rd1),
    .ex_rd2       (ex_rd2),
    .ex_imm       (ex_imm),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_rd        (ex_rd),
    .ex_valid     (ex_valid),
    .bubble_cnt   (bubble_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic v);
    stall = v; flush = v; hold = v; id_valid = v;
    reg_dst_in = v; alu_src_in = v; mem_read_in = v;
    mem_write_in = v; reg_write_in = v; mem_to_reg_in = v;
    alu_op_in   = {3{v}};
    pc_plus4_in = {32{v}}; rd1_in = {32{v}}; rd2_in = {32{v}}; imm_in = {32{v}};
    rs_in = {5{v}}; rt_in = {5{v}}; rd_in = {5{v}};
  endtask

  initial begin
    // 1: reset with every input high
    set_all(1'b1);
    rst_n = 1'b0;
    step();
    step();
    check("rst_rd1",      ex_rd1, 32'h0);
    check("rst_pc",       ex_pc_plus4, 32'h0);
    check("rst_rt",       32'(ex_rt), 32'h0);
    check("rst_mem_read", 32'(ex_mem_read), 32'h0);
    check("rst_alu_op",   32'(ex_alu_op), 32'h0);
    check("rst_valid",    32'(ex_valid), 32'h0);
    check("rst_cnt",      32'(bubble_cnt), 32'h0);
    rst_n = 1'b1;
    step();
    // hold is high, so the register stays frozen at its reset contents
    check("rst_rel_hold_rd1", ex_rd1, 32'h0);
    check("rst_rel_hold_cnt", 32'(bubble_cnt), 32'h0);
    // clean reset to drop the flush_pending captured under hold
    set_all(1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    // 2: normal load
    id_valid = 1'b1; rd1_in = 32'h1234_5678; rt_in = 5'd9; mem_read_in = 1'b1;
    alu_op_in = 3'b010; reg_write_in = 1'b1; pc_plus4_in = 32'h104; imm_in = 32'hFFFF_FFF0;
    step();
    check("n_rd1",      ex_rd1, 32'h1234_5678);
    check("n_rt",       32'(ex_rt), 32'd9);
    check("n_mem_read", 32'(ex_mem_read), 32'h1);
    check("n_alu_op",   32'(ex_alu_op), 32'h2);
    check("n_valid",    32'(ex_valid), 32'h1);
    check("n_pc",       ex_pc_plus4, 32'h104);
    check("n_imm",      ex_imm, 32'hFFFF_FFF0);
    check("n_cnt",      32'(bubble_cnt), 32'h0);

    // 3: load-use stall
    stall = 1'b1;
    step();
    check("st_reg_write", 32'(ex_reg_write), 32'h0);
    check("st_mem_read",  32'(ex_mem_read), 32'h0);
    check("st_rt",        32'(ex_rt), 32'h0);
    check("st_rd1",       ex_rd1, 32'h0);
    check("st_valid",     32'(ex_valid), 32'h0);
    check("st_cnt",       32'(bubble_cnt), 32'h1);
    stall = 1'b0; rd1_in = 32'hAAAA_5555;
    step();
    check("st_rel_rd1",  ex_rd1, 32'hAAAA_5555);
    check("st_rel_rw",   32'(ex_reg_write), 32'h1);
    check("st_rel_vld",  32'(ex_valid), 32'h1);

    // 4: hold with flush, then hold alone
    hold = 1'b1; flush = 1'b1; rd1_in = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      flush = 1'b0;
      check("hold_rd1",   ex_rd1, 32'hAAAA_5555);
      check("hold_valid", 32'(ex_valid), 32'h1);
      check("hold_cnt",   32'(bubble_cnt), 32'h1);
    end
    hold = 1'b0;
    step();
    check("pend_valid", 32'(ex_valid), 32'h0);
    check("pend_rd1",   ex_rd1, 32'h0);
    check("pend_cnt",   32'(bubble_cnt), 32'h2);
    step();
    check("pend_rel_rd1", ex_rd1, 32'hDEAD_BEEF);
    check("pend_rel_vld", 32'(ex_valid), 32'h1);
    check("pend_rel_cnt", 32'(bubble_cnt), 32'h2);

    // 5: stall and flush together count once
    stall = 1'b1; flush = 1'b1;
    step();
    check("sf_valid", 32'(ex_valid), 32'h0);
    check("sf_cnt",   32'(bubble_cnt), 32'h3);
    stall = 1'b0; flush = 1'b0;
    step();
    check("sf_rel_vld", 32'(ex_valid), 32'h1);
    check("sf_rel_cnt", 32'(bubble_cnt), 32'h3);

    // invalid ID slot: data loads, control forced low, no count
    id_valid = 1'b0; rd1_in = 32'h0BAD_F00D;
    step();
    check("iv_valid",    32'(ex_valid), 32'h0);
    check("iv_mem_read", 32'(ex_mem_read), 32'h0);
    check("iv_alu_op",   32'(ex_alu_op), 32'h0);
    check("iv_rd1",      ex_rd1, 32'h0BAD_F00D);
    check("iv_rt",       32'(ex_rt), 32'd9);
    check("iv_cnt",      32'(bubble_cnt), 32'h3);

    // 6: saturation from 3 over 20 stall cycles
    stall = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 11) check("sat_pre", 32'(bubble_cnt), 32'hE);
      if (i == 12) check("sat_hit", 32'(bubble_cnt), 32'hF);
    end
    check("sat_stay", 32'(bubble_cnt), 32'hF);
    rst_n = 1'b0;
    step();
    check("sat_rst_cnt", 32'(bubble_cnt), 32'h0);
    rst_n = 1'b1;
    step();
    check("sat_rst_cnt1", 32'(bubble_cnt), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
